sobel_frame_sched: RTL and testbench
====================================

// Module: sobel_frame_sched
// PURPOSE
// - Job scheduler sitting in front of the sobel_0 HLS core (ap_ctrl_hs handshake).
// - Accepts a job command (frame count, 6-bit working key) and runs the core once per frame.
// - Ping-pongs the frame-buffer bank between frames and holds the key stable for the whole job.
// - Guards every core run with a watchdog and reports completion, progress and errors to the host.
// PARAMETERS
// - KEY_W      6   width of working_key bus to the core
// - FRAMES_W   8   width of frame-count command field
// - TIMEOUT_W  20  watchdog width; timeout fires at 2**TIMEOUT_W-1 cycles
// PORTS
// - ap_clk          in   1          clock
// - ap_rst_n        in   1          synchronous reset, active low
// - cmd_valid       in   1          job command valid
// - cmd_ready       out  1          job command accepted when valid&ready
// - cmd_frames      in   FRAMES_W   number of frames in job (0 legal)
// - cmd_key         in   KEY_W      working key for job
// - err_clear       in   1          clears sticky error, returns FSM to IDLE
// - core_start      out  1          to core ap_start
// - core_ready      in   1          from core ap_ready
// - core_done       in   1          from core ap_done
// - core_idle       in   1          from core ap_idle
// - core_key        out  KEY_W      to core working_key
// - buf_sel         out  1          frame-buffer bank for current frame
// - busy            out  1          job in progress
// - frames_done     out  FRAMES_W   frames completed in current/last job
// - job_done        out  1          one-cycle pulse at job completion
// - err_timeout     out  1          sticky watchdog error
// - perf_cycles     out  32         cycles of last completed frame (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: cmd_ready=0, core_start=0, core_key=0, buf_sel=0, busy=0, frames_done=0,
//   job_done=0, err_timeout=0, perf_cycles=0. FSM=IDLE.
// - Reset mid-job: same values next cycle. The core is not otherwise aborted.
// - FSM states are IDLE, WAITIDLE, START, RUN, NEXT and ERR.
// - IDLE: cmd_ready=1. Accepting a command latches key and count, sets frames_done=0 and buf_sel=0.
//   - Count 0: job_done pulses the following cycle, busy stays 0, FSM stays IDLE.
//   - Otherwise: busy=1 and FSM goes to WAITIDLE.
// - WAITIDLE: waits for core_idle=1, then goes to START. The watchdog runs here.
// - START: core_start=1. Watchdog cleared on entry. core_start stays high until core_ready is
//   sampled 1 (ap_ctrl_hs). FSM goes to RUN in the same cycle as core_ready.
//   - core_ready and core_done arrive together, as the core asserts them: treat as frame complete
//     and go to NEXT directly.
// - RUN: core_start=0. Waits for core_done, then goes to NEXT.
// - NEXT (1 cycle): frames_done+1 and buf_sel toggles.
//   - frames_done equals count: job_done=1 and busy=0 the same cycle, FSM to IDLE.
//   - Otherwise: FSM to WAITIDLE.
// - Watchdog: counts in WAITIDLE, START and RUN. At all-ones it sets err_timeout and moves to ERR.
//   core_start drops the same cycle.
// - ERR: busy=1 and cmd_ready=0. err_clear (any cycle) goes to IDLE, clears err_timeout and busy.
//   No job_done pulse.
// - err_clear outside ERR is ignored.
// - cmd_valid outside IDLE is ignored (not queued).
// - core_key changes only on command acceptance. It keeps the last key after the job ends.
// - frames_done saturates by construction (count <= 2**FRAMES_W-1). It is never wrapped.
// CONFIGURATION
// - Macro: SOBEL_FRAME_SCHED_PERF_EN.
// - Defined: a 32-bit counter clears on START entry and increments every cycle until NEXT.
//   In NEXT it loads perf_cycles. The counter saturates at 32'hFFFF_FFFF.
// - Undefined: no counter logic; perf_cycles is tied to 0.
// STRUCTURE
// - sobel_sched_pkg: state enum (one-hot, 6 bits), KEY_W/FRAMES_W/TIMEOUT_W defaults,
//   watchdog terminal constant.
// - Sub-module sobel_sched_wdog: clear/enable counter with terminal-count flag, width TIMEOUT_W.
// - Top level holds the FSM, job registers and the optional perf counter.
// TESTING
// - Single frame: cmd frames=1 key=6'h2A.
//   -> core_start high until core_ready; core_key=2A.
//   -> job_done pulse 1 cycle after core_done; frames_done=1, buf_sel=1.
// - Four frames with core_done 100 cycles after start.
//   -> 4 start handshakes; buf_sel sequence 0,1,0,1.
//   -> job_done once; frames_done=4.
// - cmd frames=0 -> job_done pulse next cycle, core_start never asserted, busy stays 0.
// - TIMEOUT_W=4 and core never answers.
//   -> err_timeout=1 and core_start=0 after 15 cycles in START.
//   -> err_clear returns to IDLE with cmd_ready=1.
// - ap_rst_n=0 held 1 cycle during RUN of frame 2 -> all outputs at reset values, new command accepted.
// - PERF_EN defined, core_done 50 cycles after ready -> perf_cycles matches counted START..NEXT span;
//   undefined -> perf_cycles=0.

Source files
------------

// File: rtl/sobel_sched_pkg.sv
// rtl/sobel_sched_pkg.sv - shared state encoding, default widths and watchdog constant for the sobel frame scheduler
package sobel_sched_pkg;

    localparam int unsigned KEY_W_DEF     = 6;
    localparam int unsigned FRAMES_W_DEF  = 8;
    localparam int unsigned TIMEOUT_W_DEF = 20;

    // One-hot scheduler states.
    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_WAITIDLE = 6'b000010,
        ST_START    = 6'b000100,
        ST_RUN      = 6'b001000,
        ST_NEXT     = 6'b010000,
        ST_ERR      = 6'b100000
    } sched_state_e;

    // Watchdog terminal count for a counter of the given width (all ones).
    function automatic logic [31:0] wdog_terminal(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sobel_sched_wdog.sv
// rtl/sobel_sched_wdog.sv - clear/enable watchdog counter with terminal-count flag
module sobel_sched_wdog
    import sobel_sched_pkg::*;
#(
    parameter int unsigned W = TIMEOUT_W_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] TERM     = W'(wdog_terminal(W));
    localparam logic [W-1:0] PRE_TERM = TERM - W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // expire marks the enabled cycle that carries the count onto all-ones,
    // so it depends only on registered state and never on clr.
    assign expire = en && (count_q == PRE_TERM);

    // Clear wins over counting; the count parks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != TERM)) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sobel_frame_sched.sv
// rtl/sobel_frame_sched.sv - ap_ctrl_hs frame scheduler for sobel_0; frame perf counter under SOBEL_FRAME_SCHED_PERF_EN
module sobel_frame_sched
    import sobel_sched_pkg::*;
#(
    parameter int unsigned KEY_W     = KEY_W_DEF,
    parameter int unsigned FRAMES_W  = FRAMES_W_DEF,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [FRAMES_W-1:0] cmd_frames,
    input  logic [KEY_W-1:0]    cmd_key,
    input  logic                err_clear,
    output logic                core_start,
    input  logic                core_ready,
    input  logic                core_done,
    input  logic                core_idle,
    output logic [KEY_W-1:0]    core_key,
    output logic                buf_sel,
    output logic                busy,
    output logic [FRAMES_W-1:0] frames_done,
    output logic                job_done,
    output logic                err_timeout,
    output logic [31:0]         perf_cycles
);

    sched_state_e        state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [FRAMES_W-1:0] count_q, count_d;
    logic [FRAMES_W-1:0] frames_done_q, frames_done_d;
    logic [FRAMES_W-1:0] frames_inc;
    logic                buf_sel_q, buf_sel_d;
    logic                busy_q, busy_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                core_start_q, core_start_d;
    logic                job_done_q, job_done_d;
    logic                err_q, err_d;
    logic                last_frame;
    logic                cmd_fire;
    logic                wdog_clr;
    logic                wdog_en;
    logic                wdog_expire;

    assign cmd_fire   = cmd_valid && cmd_ready_q;
    assign frames_inc = frames_done_q + FRAMES_W'(1);
    assign wdog_en    = (state_q == ST_WAITIDLE) || (state_q == ST_START) || (state_q == ST_RUN);

    sobel_sched_wdog #(
        .W (TIMEOUT_W)
    ) u_wdog (
        .clk    (ap_clk),
        .resetn (ap_rst_n),
        .clr    (wdog_clr),
        .en     (wdog_en),
        .expire (wdog_expire)
    );

    // Next-state and registered-output decode; outputs follow the state being entered.
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        count_d       = count_q;
        frames_done_d = frames_done_q;
        buf_sel_d     = buf_sel_q;
        err_d         = err_q;
        job_done_d    = 1'b0;
        last_frame    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    key_d         = cmd_key;
                    count_d       = cmd_frames;
                    frames_done_d = '0;
                    buf_sel_d     = 1'b0;
                    if (cmd_frames == '0) begin
                        job_done_d = 1'b1;
                    end else begin
                        state_d = ST_WAITIDLE;
                    end
                end
            end
            ST_WAITIDLE: begin
                if (wdog_expire) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (core_idle) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (wdog_expire) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (core_ready) begin
                    // ready and done together means the frame already finished
                    state_d = core_done ? ST_NEXT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (wdog_expire) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (core_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_d = (frames_done_q == count_q) ? ST_IDLE : ST_WAITIDLE;
            end
            ST_ERR: begin
                if (err_clear) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame bookkeeping lands as NEXT is entered so it is visible during NEXT.
        if (state_d == ST_NEXT) begin
            frames_done_d = frames_inc;
            buf_sel_d     = ~buf_sel_q;
            last_frame    = (frames_inc == count_q);
            job_done_d    = last_frame;
        end

        wdog_clr     = (state_d != state_q) && ((state_d == ST_WAITIDLE) || (state_d == ST_START));
        cmd_ready_d  = (state_d == ST_IDLE);
        core_start_d = (state_d == ST_START);

        case (state_d)
            ST_WAITIDLE, ST_START, ST_RUN, ST_ERR: busy_d = 1'b1;
            ST_NEXT:                               busy_d = !last_frame;
            default:                               busy_d = 1'b0;
        endcase
    end

    // Scheduler state and job registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q       <= ST_IDLE;
            key_q         <= '0;
            count_q       <= '0;
            frames_done_q <= '0;
            buf_sel_q     <= 1'b0;
            busy_q        <= 1'b0;
            cmd_ready_q   <= 1'b0;
            core_start_q  <= 1'b0;
            job_done_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            count_q       <= count_d;
            frames_done_q <= frames_done_d;
            buf_sel_q     <= buf_sel_d;
            busy_q        <= busy_d;
            cmd_ready_q   <= cmd_ready_d;
            core_start_q  <= core_start_d;
            job_done_q    <= job_done_d;
            err_q         <= err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign core_start  = core_start_q;
    assign core_key    = key_q;
    assign buf_sel     = buf_sel_q;
    assign busy        = busy_q;
    assign frames_done = frames_done_q;
    assign job_done    = job_done_q;
    assign err_timeout = err_q;

`ifdef SOBEL_FRAME_SCHED_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] perf_q, perf_d;

    // Frame span counter: restarts on START entry, counts START/RUN cycles, captured in NEXT.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        perf_d     = perf_q;
        if ((state_d == ST_START) && (state_q != ST_START)) begin
            perf_cnt_d = '0;
        end else if ((state_q == ST_START) || (state_q == ST_RUN)) begin
            if (perf_cnt_q != 32'hFFFF_FFFF) begin
                perf_cnt_d = perf_cnt_q + 32'd1;
            end
        end
        if (state_q == ST_NEXT) begin
            perf_d = perf_cnt_q;
        end
    end

    // Perf registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_q     <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_sobel_frame_sched.sv
// tb/tb_sobel_frame_sched.sv - directed self-checking bench for sobel_frame_sched
module tb_sobel_frame_sched;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_frames = 8'd0;
    logic [5:0]  cmd_key = 6'd0;
    logic        err_clear = 1'b0;
    logic        core_start;
    logic        core_ready = 1'b0;
    logic        core_done = 1'b0;
    logic        core_idle = 1'b1;
    logic [5:0]  core_key;
    logic        buf_sel;
    logic        busy;
    logic [7:0]  frames_done;
    logic        job_done;
    logic        err_timeout;
    logic [31:0] perf_cycles;

    logic        cmd_valid_w = 1'b0;
    logic        cmd_ready_w;
    logic [7:0]  cmd_frames_w = 8'd2;
    logic [5:0]  cmd_key_w = 6'h09;
    logic        err_clear_w = 1'b0;
    logic        core_start_w;
    logic        core_ready_w = 1'b0;
    logic        core_done_w = 1'b0;
    logic        core_idle_w = 1'b1;
    logic [5:0]  core_key_w;
    logic        buf_sel_w;
    logic        busy_w;
    logic [7:0]  frames_done_w;
    logic        job_done_w;
    logic        err_timeout_w;
    logic [31:0] perf_cycles_w;

    int n_cmp = 0;
    int n_bad = 0;

    sobel_frame_sched #(.KEY_W(6), .FRAMES_W(8), .TIMEOUT_W(8)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_frames(cmd_frames), .cmd_key(cmd_key), .err_clear(err_clear), .core_start(core_start),
        .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle), .core_key(core_key),
        .buf_sel(buf_sel), .busy(busy), .frames_done(frames_done), .job_done(job_done),
        .err_timeout(err_timeout), .perf_cycles(perf_cycles)
    );

    sobel_frame_sched #(.KEY_W(6), .FRAMES_W(8), .TIMEOUT_W(4)) dut_wd (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_valid(cmd_valid_w), .cmd_ready(cmd_ready_w),
        .cmd_frames(cmd_frames_w), .cmd_key(cmd_key_w), .err_clear(err_clear_w), .core_start(core_start_w),
        .core_ready(core_ready_w), .core_done(core_done_w), .core_idle(core_idle_w), .core_key(core_key_w),
        .buf_sel(buf_sel_w), .busy(busy_w), .frames_done(frames_done_w), .job_done(job_done_w),
        .err_timeout(err_timeout_w), .perf_cycles(perf_cycles_w)
    );

    // One-cycle command pulse; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [7:0] f, input logic [5:0] k);
        cmd_frames = f;
        cmd_key    = k;
        cmd_valid  = 1'b1;
        @(negedge ap_clk);
        cmd_valid  = 1'b0;
    endtask

    // Core model for one frame: ready w cycles after start seen, done d cycles after ready.
    // Returns at the negedge of the NEXT cycle.
    task automatic drive_frame(input int w, input int d, output int start_hi,
                               output logic start_after, output logic buf_seen, output logic ok);
        int t = 0;
        ok = 1'b1; start_hi = 0; start_after = 1'b1; buf_seen = 1'b0;
        while (core_start !== 1'b1 && t < 50) begin
            @(negedge ap_clk);
            t++;
        end
        if (core_start !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        buf_seen = buf_sel;
        for (int i = 0; i <= w; i++) begin
            if (core_start === 1'b1) start_hi++;
            if (i < w) @(negedge ap_clk);
        end
        core_ready = 1'b1;
        if (d == 0) core_done = 1'b1;
        @(negedge ap_clk);
        start_after = core_start;
        core_ready = 1'b0;
        core_done  = 1'b0;
        if (d > 0) begin
            repeat (d - 1) @(negedge ap_clk);
            core_done = 1'b1;
            @(negedge ap_clk);
            core_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [51:0] vec;
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        vec = {cmd_ready, core_start, core_key, buf_sel, busy, frames_done, job_done, err_timeout, perf_cycles};
        n_cmp++; if (vec !== 52'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", vec); end
        n_cmp++; if ({cmd_ready_w, busy_w, err_timeout_w} !== 3'b000) begin n_bad++; $display("FAIL reset_wd_outputs: got %b want 000", {cmd_ready_w, busy_w, err_timeout_w}); end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        int sh; logic sa, bs, ok;
        err_clear = 1'b1;
        send_cmd(8'd1, 6'h2A);
        n_cmp++; if (core_key !== 6'h2A) begin n_bad++; $display("FAIL single_key: got %h want 2a", core_key); end
        n_cmp++; if ({busy, cmd_ready} !== 2'b10) begin n_bad++; $display("FAIL single_busy_ready: got %b want 10", {busy, cmd_ready}); end
        drive_frame(2, 3, sh, sa, bs, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_start_seen: got %b want 1", ok); end
        n_cmp++; if (sh !== 3) begin n_bad++; $display("FAIL single_start_width: got %0d want 3", sh); end
        n_cmp++; if (sa !== 1'b0) begin n_bad++; $display("FAIL single_start_drop: got %b want 0", sa); end
        n_cmp++; if (bs !== 1'b0) begin n_bad++; $display("FAIL single_buf_run: got %b want 0", bs); end
        n_cmp++; if ({job_done, busy, buf_sel, err_timeout} !== 4'b1010) begin n_bad++; $display("FAIL single_done: got %b want 1010", {job_done, busy, buf_sel, err_timeout}); end
        n_cmp++; if (frames_done !== 8'd1) begin n_bad++; $display("FAIL single_frames: got %0d want 1", frames_done); end
        err_clear = 1'b0;
        @(negedge ap_clk);
        n_cmp++; if ({job_done, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL single_after: got %b want 01", {job_done, cmd_ready}); end
        n_cmp++; if (core_key !== 6'h2A) begin n_bad++; $display("FAIL single_key_kept: got %h want 2a", core_key); end
`ifdef SOBEL_FRAME_SCHED_PERF_EN
        n_cmp++; if (perf_cycles !== 32'd6) begin n_bad++; $display("FAIL single_perf: got %0d want 6", perf_cycles); end
`else
        n_cmp++; if (perf_cycles !== 32'd0) begin n_bad++; $display("FAIL single_perf: got %0d want 0", perf_cycles); end
`endif
    endtask

    task automatic test_four_frames();
        int sh; logic sa, bs, ok;
        int hs = 0;
        int jd = 0;
        logic [3:0] bufs = 4'b0;
        cmd_frames = 8'd4; cmd_key = 6'h11; cmd_valid = 1'b1;
        @(negedge ap_clk);
        // held command during the job must be ignored
        cmd_frames = 8'd7; cmd_key = 6'h3F;
        for (int f = 0; f < 4; f++) begin
            drive_frame(0, 100, sh, sa, bs, ok);
            if (ok && sh == 1 && !sa) hs++;
            bufs[f] = bs;
            if (job_done === 1'b1) jd++;
        end
        cmd_valid = 1'b0;
        n_cmp++; if (hs !== 4) begin n_bad++; $display("FAIL four_handshakes: got %0d want 4", hs); end
        n_cmp++; if (bufs !== 4'b1010) begin n_bad++; $display("FAIL four_buf_seq: got %b want 1010", bufs); end
        n_cmp++; if (jd !== 1) begin n_bad++; $display("FAIL four_job_done_count: got %0d want 1", jd); end
        n_cmp++; if (frames_done !== 8'd4) begin n_bad++; $display("FAIL four_frames: got %0d want 4", frames_done); end
        n_cmp++; if ({core_key, buf_sel} !== {6'h11, 1'b0}) begin n_bad++; $display("FAIL four_key_buf: got %h want 22", {core_key, buf_sel}); end
        @(negedge ap_clk);
        n_cmp++; if ({job_done, cmd_ready, busy} !== 3'b010) begin n_bad++; $display("FAIL four_after: got %b want 010", {job_done, cmd_ready, busy}); end
    endtask

    task automatic test_zero_frames();
        logic seen_start = 1'b0;
        logic seen_busy = 1'b0;
        logic seen_jd = 1'b0;
        send_cmd(8'd0, 6'h05);
        n_cmp++; if ({job_done, busy, cmd_ready} !== 3'b101) begin n_bad++; $display("FAIL zero_pulse: got %b want 101", {job_done, busy, cmd_ready}); end
        n_cmp++; if ({core_key, frames_done} !== {6'h05, 8'd0}) begin n_bad++; $display("FAIL zero_regs: got %h want 0500", {core_key, frames_done}); end
        repeat (5) begin
            @(negedge ap_clk);
            seen_start |= core_start; seen_busy |= busy; seen_jd |= job_done;
        end
        n_cmp++; if ({seen_start, seen_busy, seen_jd} !== 3'b000) begin n_bad++; $display("FAIL zero_quiet: got %b want 000", {seen_start, seen_busy, seen_jd}); end
    endtask

    task automatic test_timeout();
        int t = 0;
        int n = 0;
        n_cmp++; if (cmd_ready_w !== 1'b1) begin n_bad++; $display("FAIL wd_ready: got %b want 1", cmd_ready_w); end
        cmd_valid_w = 1'b1;
        @(negedge ap_clk);
        cmd_valid_w = 1'b0;
        while (core_start_w !== 1'b1 && t < 10) begin @(negedge ap_clk); t++; end
        while (core_start_w === 1'b1 && n < 40) begin n++; @(negedge ap_clk); end
        n_cmp++; if (n !== 15) begin n_bad++; $display("FAIL wd_start_cycles: got %0d want 15", n); end
        n_cmp++; if ({err_timeout_w, busy_w, cmd_ready_w, core_start_w} !== 4'b1100) begin n_bad++; $display("FAIL wd_err_state: got %b want 1100", {err_timeout_w, busy_w, cmd_ready_w, core_start_w}); end
        n_cmp++; if ({core_key_w, frames_done_w, buf_sel_w} !== {6'h09, 8'd0, 1'b0}) begin n_bad++; $display("FAIL wd_regs: got %h", {core_key_w, frames_done_w, buf_sel_w}); end
        n_cmp++; if (perf_cycles_w !== 32'd0) begin n_bad++; $display("FAIL wd_perf: got %0d want 0", perf_cycles_w); end
        cmd_valid_w = 1'b1;
        @(negedge ap_clk);
        cmd_valid_w = 1'b0;
        @(negedge ap_clk);
        n_cmp++; if ({err_timeout_w, core_start_w, busy_w} !== 3'b101) begin n_bad++; $display("FAIL wd_cmd_ignored: got %b want 101", {err_timeout_w, core_start_w, busy_w}); end
        err_clear_w = 1'b1;
        @(negedge ap_clk);
        err_clear_w = 1'b0;
        n_cmp++; if ({err_timeout_w, busy_w, cmd_ready_w, job_done_w} !== 4'b0010) begin n_bad++; $display("FAIL wd_clear: got %b want 0010", {err_timeout_w, busy_w, cmd_ready_w, job_done_w}); end
    endtask

    task automatic test_reset_mid_job();
        int sh; logic sa, bs, ok;
        int t = 0;
        logic [51:0] vec;
        send_cmd(8'd3, 6'h15);
        drive_frame(0, 2, sh, sa, bs, ok);
        n_cmp++; if ({ok, frames_done} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL mid_frame1: got %h want 101", {ok, frames_done}); end
        while (core_start !== 1'b1 && t < 50) begin @(negedge ap_clk); t++; end
        n_cmp++; if ({core_start, buf_sel} !== 2'b11) begin n_bad++; $display("FAIL mid_frame2_start: got %b want 11", {core_start, buf_sel}); end
        core_ready = 1'b1;
        @(negedge ap_clk);
        core_ready = 1'b0;
        n_cmp++; if ({core_start, busy} !== 2'b01) begin n_bad++; $display("FAIL mid_in_run: got %b want 01", {core_start, busy}); end
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        vec = {cmd_ready, core_start, core_key, buf_sel, busy, frames_done, job_done, err_timeout, perf_cycles};
        n_cmp++; if (vec !== 52'd0) begin n_bad++; $display("FAIL mid_reset_outputs: got %h want 0", vec); end
        @(negedge ap_clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
        send_cmd(8'd1, 6'h07);
        n_cmp++; if ({core_key, busy} !== {6'h07, 1'b1}) begin n_bad++; $display("FAIL mid_new_cmd: got %h want 0f", {core_key, busy}); end
        drive_frame(0, 1, sh, sa, bs, ok);
        n_cmp++; if ({ok, job_done, buf_sel, frames_done} !== {3'b111, 8'd1}) begin n_bad++; $display("FAIL mid_new_job: got %h want 701", {ok, job_done, buf_sel, frames_done}); end
        @(negedge ap_clk);
    endtask

    task automatic test_perf();
        int sh; logic sa, bs, ok;
        send_cmd(8'd1, 6'h30);
        drive_frame(1, 50, sh, sa, bs, ok);
        n_cmp++; if ({ok, job_done} !== 2'b11) begin n_bad++; $display("FAIL perf_job: got %b want 11", {ok, job_done}); end
        @(negedge ap_clk);
`ifdef SOBEL_FRAME_SCHED_PERF_EN
        n_cmp++; if (perf_cycles !== 32'd52) begin n_bad++; $display("FAIL perf_cycles: got %0d want 52", perf_cycles); end
`else
        n_cmp++; if (perf_cycles !== 32'd0) begin n_bad++; $display("FAIL perf_cycles: got %0d want 0", perf_cycles); end
`endif
    endtask

    initial begin
        @(negedge ap_clk);
        test_reset();
        test_single();
        test_four_frames();
        test_zero_frames();
        test_timeout();
        test_reset_mid_job();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
